// File: rtl/bp_me_cce_to_cache_arbiter_pkg.sv
// Shared types and helpers for the cce-to-cache arbiter slice.
package bp_me_cce_to_cache_arbiter_pkg;

   typedef enum logic [0:0] {
      e_arb_idle   = 1'b0,
      e_arb_locked = 1'b1
   } bp_me_arb_state_e;

   // Default BedRock mem message width when no processor config is supplied.
   localparam int cce_mem_msg_width_lp = 32;

   // clog2 that never returns 0, so a width derived from it is always legal.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bp_me_cce_to_cache_arbiter_id_fifo.sv
// In-order FIFO of granted requester IDs with asynchronous active-low reset.
// A push while full is dropped; there is no full bypass.
module bp_me_id_fifo
   import bp_me_cce_to_cache_arbiter_pkg::*;
#(
   parameter int width_p = 1,
   parameter int els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i,
   output logic               full_o,
   output logic               empty_o
);

   localparam int ptr_w_lp = safe_clog2(els_p);
   localparam int cnt_w_lp = safe_clog2(els_p + 1);

   logic [width_p-1:0]  mem_r [els_p];
   logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
   logic [cnt_w_lp-1:0] count_r;
   logic                push, pop;

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_r == cnt_w_lp'(els_p));
   assign empty_o = (count_r == '0);
   assign push    = v_i & ~full_o;
   assign pop     = yumi_i & ~empty_o;
   assign data_o  = mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
         if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
         count_r <= count_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
      end
   end

   // ID storage; contents are don't-care while empty so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push) mem_r[wr_ptr_r] <= data_i;
   end

endmodule

// File: rtl/bp_me_cce_to_cache_arbiter.sv
// Round-robin arbiter sharing one cce-to-cache converter between requesters.
// Commands pass through combinationally; the granted ID is queued so each
// in-order converter response is steered back to the requester that issued it.
//
//   state        | meaning
//   e_arb_idle   | round-robin search from last_grant_r+1 picks the grant
//   e_arb_locked | converter stalled a presented command; grant held on lock_id_r
module bp_me_cce_to_cache_arbiter
   import bp_me_cce_to_cache_arbiter_pkg::*;
#(
   parameter int num_req_p           = 2,
   parameter int id_fifo_els_p       = 4,
   parameter int cce_mem_msg_width_p = cce_mem_msg_width_lp
) (
   input  logic                                     clk_i,
   input  logic                                     reset_n_i,
   input  logic [num_req_p*cce_mem_msg_width_p-1:0] mem_cmd_i,
   input  logic [num_req_p-1:0]                     mem_cmd_v_i,
   output logic [num_req_p-1:0]                     mem_cmd_ready_and_o,
   output logic [cce_mem_msg_width_p-1:0]           mem_resp_o,
   output logic [num_req_p-1:0]                     mem_resp_v_o,
   input  logic [num_req_p-1:0]                     mem_resp_yumi_i,
   output logic [cce_mem_msg_width_p-1:0]           mem_cmd_o,
   output logic                                     mem_cmd_v_o,
   input  logic                                     mem_cmd_ready_and_i,
   input  logic [cce_mem_msg_width_p-1:0]           mem_resp_i,
   input  logic                                     mem_resp_v_i,
   output logic                                     mem_resp_yumi_o
);

   localparam int lg_num_req_lp = safe_clog2(num_req_p);

   bp_me_arb_state_e         state_r, state_n;
   logic [lg_num_req_lp-1:0] lock_id_r, last_grant_r;
   logic [lg_num_req_lp-1:0] rr_grant, grant, head;
   logic                     rr_found, sel_v, cmd_hs;
   logic                     id_full, id_empty;
   logic [cce_mem_msg_width_p-1:0] cmd_arr [num_req_p];

   for (genvar g = 0; g < num_req_p; g++) begin : g_split
      assign cmd_arr[g] = mem_cmd_i[g*cce_mem_msg_width_p +: cce_mem_msg_width_p];
   end

   // Round-robin search: first valid requester after the last grant, wrapping.
   always_comb begin
      rr_grant = last_grant_r;
      rr_found = 1'b0;
      for (int i = 1; i <= num_req_p; i++) begin
         int idx;
         idx = (int'(last_grant_r) + i) % num_req_p;
         if (!rr_found && mem_cmd_v_i[lg_num_req_lp'(idx)]) begin
            rr_grant = lg_num_req_lp'(idx);
            rr_found = 1'b1;
         end
      end
   end

   assign grant       = (state_r == e_arb_locked) ? lock_id_r : rr_grant;
   assign sel_v       = (state_r == e_arb_locked) ? mem_cmd_v_i[lock_id_r] : |mem_cmd_v_i;
   assign mem_cmd_v_o = reset_n_i & sel_v & ~id_full;
   assign mem_cmd_o   = cmd_arr[grant];
   assign cmd_hs      = mem_cmd_v_o & mem_cmd_ready_and_i;

   // Only the granted requester sees ready, and only on an actual handshake.
   always_comb begin
      mem_cmd_ready_and_o        = '0;
      mem_cmd_ready_and_o[grant] = cmd_hs;
   end

   // Next state: lock when the converter stalls a presented command.
   always_comb begin
      state_n = state_r;
      case (state_r)
         e_arb_idle:   if (mem_cmd_v_o && !mem_cmd_ready_and_i) state_n = e_arb_locked;
         e_arb_locked: if (cmd_hs) state_n = e_arb_idle;
         default:      state_n = e_arb_idle;
      endcase
   end

   // State, lock ID and round-robin pointer registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r      <= e_arb_idle;
         lock_id_r    <= '0;
         last_grant_r <= lg_num_req_lp'(num_req_p - 1);
      end else begin
         state_r <= state_n;
         if (state_r == e_arb_idle && state_n == e_arb_locked) lock_id_r <= grant;
         if (cmd_hs) last_grant_r <= grant;
      end
   end

   bp_me_id_fifo #(
      .width_p (lg_num_req_lp),
      .els_p   (id_fifo_els_p)
   ) id_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (grant),
      .v_i       (cmd_hs),
      .data_o    (head),
      .yumi_i    (mem_resp_yumi_o),
      .full_o    (id_full),
      .empty_o   (id_empty)
   );

   assign mem_resp_o      = mem_resp_i;
   assign mem_resp_yumi_o = reset_n_i & mem_resp_yumi_i[head] & ~id_empty;

   // Response valid goes only to the requester at the head of the ID FIFO.
   always_comb begin
      mem_resp_v_o = '0;
      for (int j = 0; j < num_req_p; j++)
         mem_resp_v_o[j] = reset_n_i & mem_resp_v_i & ~id_empty & (head == lg_num_req_lp'(j));
   end

   a_resp_without_cmd: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(mem_resp_v_i && id_empty))
      else $error("converter response with no outstanding command");

   a_yumi_not_head: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(mem_resp_v_i && !id_empty && |(mem_resp_yumi_i & ~mem_resp_v_o)))
      else $error("response yumi from a requester that is not at the ID FIFO head");

endmodule
